// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the Q3.28 datapath (multiplier and divider):
// default widths, saturation constants, FSM state encoding and sign helpers.
package fixed_point_pkg;

  localparam int DEF_W    = 32;
  localparam int DEF_FRAC = 28;

  localparam logic [DEF_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [DEF_W-1:0] SAT_NEG = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Two's-complement negation.
  function automatic logic [DEF_W-1:0] fx_negate(input logic [DEF_W-1:0] x);
    return ~x + 32'd1;
  endfunction

  // Unsigned magnitude; the most negative value maps to 0x80000000 unsigned.
  function automatic logic [DEF_W-1:0] fx_abs(input logic [DEF_W-1:0] x);
    logic [DEF_W-1:0] r;
    if (x[DEF_W-1]) begin
      r = fx_negate(x);
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_point_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder
// and subtract the divisor when it fits. Purely combinational.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic         q_bit
);

  logic [W:0] shifted_s;
  logic [W:0] diff_s;

  // Trial subtraction; a set rem[W] means the shifted value exceeds any divisor.
  always_comb begin
    shifted_s = {rem[W-1:0], din};
    diff_s    = shifted_s - {1'b0, divisor};
    if (rem[W] || (shifted_s >= {1'b0, divisor})) begin
      rem_next = diff_s;
      q_bit    = 1'b1;
    end else begin
      rem_next = shifted_s;
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/fixed_point_divider.sv
// Iterative signed Q3.28 divider: sign-magnitude restoring division, one
// quotient bit per clock, saturating result, valid/ready on both sides.
module fixed_point_divider
  import fixed_point_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int NBITS = W + FRAC;
  localparam int CNT_W = $clog2(NBITS + 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] count_r;
  logic [NBITS-1:0] dividend_r;
  logic [NBITS-1:0] quot_r;
  logic [W:0]       rem_r;
  logic [W-1:0]     divisor_r;
  logic             sign_r;
  logic             dbz_r;

  logic             in_ready_r;
  logic             out_valid_r;
  logic [W-1:0]     result_r;
  logic             div_by_zero_r;
  logic             overflow_r;

  logic [W:0]       rem_next_s;
  logic             q_bit_s;
  logic [NBITS:0]   q_next_s;
  logic [W-1:0]     mag_s;
  logic             mag_big_s;
  logic [W-1:0]     fin_result_s;
  logic             fin_ovf_s;

  div_step #(.W(W)) u_div_step (
    .rem      (rem_r),
    .din      (dividend_r[NBITS-1]),
    .divisor  (divisor_r),
    .rem_next (rem_next_s),
    .q_bit    (q_bit_s)
  );

  assign q_next_s = {quot_r, q_bit_s};

  // Sign application and saturation of the final magnitude quotient.
  always_comb begin
    mag_s        = q_next_s[W-1:0];
    mag_big_s    = |q_next_s[NBITS:W];
    fin_result_s = {W{1'b0}};
    fin_ovf_s    = 1'b0;
    if (mag_big_s || (mag_s > SAT_POS)) begin
      // Exactly 2^31 with a negative sign is representable as 0x80000000.
      if (sign_r && !mag_big_s && (mag_s == SAT_NEG)) begin
        fin_result_s = SAT_NEG;
        fin_ovf_s    = 1'b0;
      end else begin
        fin_result_s = sign_r ? SAT_NEG : SAT_POS;
        fin_ovf_s    = 1'b1;
      end
    end else begin
      fin_result_s = sign_r ? fx_negate(mag_s) : mag_s;
      fin_ovf_s    = 1'b0;
    end
  end

  // Handshake FSM, iteration control and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      count_r       <= {CNT_W{1'b0}};
      dividend_r    <= {NBITS{1'b0}};
      quot_r        <= {NBITS{1'b0}};
      rem_r         <= {(W+1){1'b0}};
      divisor_r     <= {W{1'b0}};
      sign_r        <= 1'b0;
      dbz_r         <= 1'b0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      result_r      <= {W{1'b0}};
      div_by_zero_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            divisor_r  <= fx_abs(b);
            dividend_r <= {fx_abs(a), {FRAC{1'b0}}};
            rem_r      <= {(W+1){1'b0}};
            quot_r     <= {NBITS{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= S_CALC;
            if (b == {W{1'b0}}) begin
              // Divide by zero spends one cycle in CALC, then reports.
              dbz_r   <= 1'b1;
              sign_r  <= a[W-1];
              count_r <= CNT_W'(1);
            end else begin
              dbz_r   <= 1'b0;
              sign_r  <= a[W-1] ^ b[W-1];
              count_r <= CNT_W'(NBITS);
            end
          end
        end
        S_CALC: begin
          if (dbz_r) begin
            state_r       <= S_DONE;
            out_valid_r   <= 1'b1;
            result_r      <= sign_r ? SAT_NEG : SAT_POS;
            div_by_zero_r <= 1'b1;
            overflow_r    <= 1'b1;
          end else begin
            rem_r      <= rem_next_s;
            quot_r     <= q_next_s[NBITS-1:0];
            dividend_r <= {dividend_r[NBITS-2:0], 1'b0};
            count_r    <= count_r - CNT_W'(1);
            if (count_r == CNT_W'(1)) begin
              state_r       <= S_DONE;
              out_valid_r   <= 1'b1;
              result_r      <= fin_result_s;
              div_by_zero_r <= 1'b0;
              overflow_r    <= fin_ovf_s;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign result      = result_r;
  assign div_by_zero = div_by_zero_r;
  assign overflow    = overflow_r;

endmodule
